// File: rtl/booth_r4_ctrl.sv
// Radix-4 Booth multiplier control unit: FSM, iteration counter and Booth digit decode.
// Define BOOTH_ZERO_SKIP_EN to fold the shift into ARITH for zero digits (000/111).
module booth_r4_ctrl #(
    parameter int unsigned N = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:-1] q_low,
    output logic        c0,
    output logic        c1,
    output logic        c2,
    output logic        c3,
    output logic        c4,
    output logic        c5,
    output logic [1:0]  shift_inc,
    output logic        sel_2m,
    output logic        c6,
    output logic        c7,
    output logic        busy,
    output logic        done
);
    localparam int unsigned CNT_W = $clog2(N / 2);
    localparam logic [CNT_W-1:0] LastIter = CNT_W'(N / 2 - 1);

    typedef enum logic [3:0] {
        StIdle, StInit, StLoadQ, StLoadM, StArith, StShift, StOutA, StOutQ, StDone
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_last;
    logic              w_skip;

    assign w_last = (r_cnt == LastIter);

`ifdef BOOTH_ZERO_SKIP_EN
    assign w_skip = (q_low == 3'b000) || (q_low == 3'b111);
`else
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            StIdle:  if (start) w_state_next = StInit;
            StInit: begin
                w_cnt_next   = '0;
                w_state_next = StLoadQ;
            end
            StLoadQ: w_state_next = StLoadM;
            StLoadM: w_state_next = StArith;
            StArith: begin
                // A zero digit may retire its shift here instead of visiting SHIFT
                if (w_skip) begin
                    w_cnt_next   = r_cnt + CNT_W'(1);
                    w_state_next = w_last ? StOutA : StArith;
                end else begin
                    w_state_next = StShift;
                end
            end
            StShift: begin
                w_cnt_next   = r_cnt + CNT_W'(1);
                w_state_next = w_last ? StOutA : StArith;
            end
            StOutA:  w_state_next = StOutQ;
            StOutQ:  w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        c0        = 1'b0;
        c1        = 1'b0;
        c2        = 1'b0;
        c3        = 1'b0;
        c4        = 1'b0;
        c5        = 1'b0;
        shift_inc = 2'b00;
        sel_2m    = 1'b0;
        c6        = 1'b0;
        c7        = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            StInit: begin
                c0   = 1'b1;
                busy = 1'b1;
            end
            StLoadQ: begin
                c1   = 1'b1;
                busy = 1'b1;
            end
            StLoadM: begin
                c2   = 1'b1;
                busy = 1'b1;
            end
            StArith: begin
                busy = 1'b1;
                if (w_skip) begin
                    c5        = 1'b1;
                    shift_inc = 2'b10;
                end else begin
                    case (q_low)
                        3'b001, 3'b010: c3 = 1'b1;
                        3'b011: begin
                            c3     = 1'b1;
                            sel_2m = 1'b1;
                        end
                        3'b100: begin
                            c4     = 1'b1;
                            sel_2m = 1'b1;
                        end
                        3'b101, 3'b110: c4 = 1'b1;
                        default: ;
                    endcase
                end
            end
            StShift: begin
                c5        = 1'b1;
                shift_inc = 2'b10;
                busy      = 1'b1;
            end
            StOutA: begin
                c6   = 1'b1;
                busy = 1'b1;
            end
            StOutQ: begin
                c7   = 1'b1;
                busy = 1'b1;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_booth_r4_ctrl.sv
// Bench for booth_r4_ctrl: a behavioural radix-4 datapath closes the q_low loop, and a
// scoreboard of expected per-cycle control words and products is checked against the DUT.
module tb_booth_r4_ctrl;
    localparam int unsigned N = 8;

    localparam logic [12:0] M_C0   = 13'h1000;
    localparam logic [12:0] M_C1   = 13'h0800;
    localparam logic [12:0] M_C2   = 13'h0400;
    localparam logic [12:0] M_C3   = 13'h0200;
    localparam logic [12:0] M_C4   = 13'h0100;
    localparam logic [12:0] M_C5   = 13'h0080;
    localparam logic [12:0] M_SH   = 13'h0040;
    localparam logic [12:0] M_SEL  = 13'h0010;
    localparam logic [12:0] M_C6   = 13'h0008;
    localparam logic [12:0] M_C7   = 13'h0004;
    localparam logic [12:0] M_BUSY = 13'h0002;
    localparam logic [12:0] M_DONE = 13'h0001;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:-1] q_low;
    logic        c0, c1, c2, c3, c4, c5, c6, c7;
    logic [1:0]  shift_inc;
    logic        sel_2m, busy, done;

    int total;
    int bad;

    logic [12:0] exp_q[$];
    logic [15:0] prod_q[$];

    logic signed [N+1:0]   r_a;
    logic [N-1:0]          r_q;
    logic                  r_qm1;
    logic [N-1:0]          r_m;
    logic [1:0]            r_idx;
    logic [N-1:0]          mult_bus;
    logic [N-1:0]          mcand_bus;
    logic                  ovr;
    logic [2:0]            ovr_dg [4];
    logic [N-1:0]          out_hi;
    logic signed [N+1:0]   w_m1;
    logic signed [N+1:0]   w_m2;
    logic signed [2*N+2:0] w_cat;
    logic signed [2*N+2:0] w_sh;
    logic [12:0]           w_obs;

    booth_r4_ctrl #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .q_low     (q_low),
        .c0        (c0),
        .c1        (c1),
        .c2        (c2),
        .c3        (c3),
        .c4        (c4),
        .c5        (c5),
        .shift_inc (shift_inc),
        .sel_2m    (sel_2m),
        .c6        (c6),
        .c7        (c7),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign w_obs = {c0, c1, c2, c3, c4, c5, shift_inc, sel_2m, c6, c7, busy, done};
    assign w_m1  = {{2{r_m[N-1]}}, r_m};
    assign w_m2  = w_m1 <<< 1;
    assign w_cat = {r_a, r_q, r_qm1};
    assign w_sh  = w_cat >>> 2;
    assign q_low = ovr ? ovr_dg[r_idx] : {r_q[1], r_q[0], r_qm1};

    // Datapath model: A is N+2 bits so +/-2M never overflows before the shift
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a <= '0; r_q <= '0; r_qm1 <= 1'b0; r_m <= '0; r_idx <= '0;
        end else begin
            if (c0) begin
                r_a <= '0; r_qm1 <= 1'b0; r_idx <= '0;
            end
            if (c1) r_q <= mult_bus;
            if (c2) r_m <= mcand_bus;
            if (c3) r_a <= r_a + (sel_2m ? w_m2 : w_m1);
            if (c4) r_a <= r_a - (sel_2m ? w_m2 : w_m1);
            if (c5) begin
                r_a   <= w_sh[2*N+2:N+1];
                r_q   <= w_sh[N:1];
                r_qm1 <= w_sh[0];
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    function automatic logic [12:0] arith_word(input logic [2:0] d);
        case (d)
            3'b001, 3'b010: return M_C3;
            3'b011:         return M_C3 | M_SEL;
            3'b100:         return M_C4 | M_SEL;
            3'b101, 3'b110: return M_C4;
            default:        return 13'h0000;
        endcase
    endfunction

    function automatic logic [11:0] digits_of(input logic [7:0] q);
        return {q[7:5], q[5:3], q[3:1], q[1:0], 1'b0};
    endfunction

    task automatic push_trace(input logic [11:0] dgs);
        logic [2:0] d;
        bit         skip;
        exp_q.push_back(M_C0 | M_BUSY);
        exp_q.push_back(M_C1 | M_BUSY);
        exp_q.push_back(M_C2 | M_BUSY);
        for (int i = 0; i < 4; i++) begin
            d    = dgs[3*i +: 3];
            skip = 1'b0;
`ifdef BOOTH_ZERO_SKIP_EN
            skip = (d == 3'b000) || (d == 3'b111);
`endif
            if (skip) begin
                exp_q.push_back(M_C5 | M_SH | M_BUSY);
            end else begin
                exp_q.push_back(arith_word(d) | M_BUSY);
                exp_q.push_back(M_C5 | M_SH | M_BUSY);
            end
        end
        exp_q.push_back(M_C6 | M_BUSY);
        exp_q.push_back(M_C7 | M_BUSY);
        exp_q.push_back(M_DONE);
        repeat (3) exp_q.push_back(13'h0000);
    endtask

    // mode 0: single start pulse, 1: start held until DONE, 2: extra start pulses while busy/DONE
    task automatic run_seq(input string name, input logic [7:0] qv, input logic [7:0] mv,
                           input bit use_ovr, input logic [11:0] odg, input int mode,
                           output int lat);
        logic [11:0]        dgs;
        logic signed [15:0] p;
        logic [15:0]        pe;
        logic [12:0]        e;
        int                 n;
        int                 done_idx;
        dgs = use_ovr ? odg : digits_of(qv);
        ovr = use_ovr;
        for (int i = 0; i < 4; i++) ovr_dg[i] = odg[3*i +: 3];
        mult_bus  = qv;
        mcand_bus = mv;
        push_trace(dgs);
        if (!use_ovr) begin
            p = $signed(qv) * $signed(mv);
            prod_q.push_back(p);
        end
        n        = exp_q.size();
        done_idx = n - 4;
        lat      = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (mode != 1) start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (w_obs !== e) begin
                bad++;
                $display("FAIL %s step %0d: ctrl got %b want %b", name, i, w_obs, e);
            end
            total++;
            if ((c3 & c4) || (sel_2m & ~(c3 | c4))) begin
                bad++;
                $display("FAIL %s excl step %0d: c3=%b c4=%b sel_2m=%b want c3&c4=0, sel only with c3/c4",
                         name, i, c3, c4, sel_2m);
            end
            if (done === 1'b1 && lat < 0) lat = i + 1;
            if (c6 === 1'b1) out_hi = r_a[N-1:0];
            if (c7 === 1'b1 && prod_q.size() > 0) begin
                pe = prod_q.pop_front();
                total++;
                if ({out_hi, r_q} !== pe) begin
                    bad++;
                    $display("FAIL %s product: got %h want %h", name, {out_hi, r_q}, pe);
                end
            end
            if (mode == 1 && i == done_idx) start = 1'b0;
            if (mode == 2) start = (i == 3 || i == 8 || i == done_idx);
        end
        start = 1'b0;
        ovr   = 1'b0;
    endtask

    task automatic check_lat(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (w_obs !== 13'h0000) begin
            bad++;
            $display("FAIL reset_state: got %b want 0", w_obs);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (w_obs !== 13'h0000) begin
            bad++;
            $display("FAIL idle_after_reset: got %b want 0", w_obs);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        ovr       = 1'b0;
        mult_bus  = 8'd3;
        mcand_bus = 8'd5;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        total++;
        if (w_obs !== (M_C3 | M_BUSY)) begin
            bad++;
            $display("FAIL mid_second_arith: got %b want %b", w_obs, M_C3 | M_BUSY);
        end
        reset = 1'b1;
        #1;
        total++;
        if (w_obs !== 13'h0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_outputs: got %b busy=%b want 0", w_obs, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (w_obs !== 13'h0000) begin
            bad++;
            $display("FAIL no_resume: got %b want 0", w_obs);
        end
        run_seq("restart", 8'd3, 8'd5, 1'b0, 12'h0, 0, lat);
    endtask

    task automatic test_basic();
        int lat;
        run_seq("q3_m5", 8'd3, 8'd5, 1'b0, 12'h0, 0, lat);
`ifdef BOOTH_ZERO_SKIP_EN
        check_lat("q3_m5", lat, 12);
`else
        check_lat("q3_m5", lat, 14);
`endif
    endtask

    task automatic test_negative();
        int lat;
        run_seq("qm128_m2", 8'h80, 8'd2, 1'b0, 12'h0, 0, lat);
`ifdef BOOTH_ZERO_SKIP_EN
        check_lat("qm128_m2", lat, 11);
`else
        check_lat("qm128_m2", lat, 14);
`endif
    endtask

    task automatic test_zero_skip();
        int lat;
        run_seq("q0_m7", 8'h00, 8'd7, 1'b0, 12'h0, 0, lat);
`ifdef BOOTH_ZERO_SKIP_EN
        check_lat("q0_m7", lat, 10);
`else
        check_lat("q0_m7", lat, 14);
`endif
    endtask

    task automatic test_start_behaviour();
        int lat;
        run_seq("start_held", 8'h5A, 8'hC3, 1'b0, 12'h0, 1, lat);
        run_seq("start_pulsed", 8'hA7, 8'h19, 1'b0, 12'h0, 2, lat);
        run_seq("second_start", 8'h7F, 8'h81, 1'b0, 12'h0, 0, lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        run_seq("b2b_a", 8'hFF, 8'hFF, 1'b0, 12'h0, 0, lat);
        run_seq("b2b_b", 8'h55, 8'h80, 1'b0, 12'h0, 0, lat);
    endtask

    task automatic test_all_codes();
        int lat;
        run_seq("codes_lo", 8'h00, 8'h00, 1'b1, {3'b011, 3'b010, 3'b001, 3'b000}, 0, lat);
        run_seq("codes_hi", 8'h00, 8'h00, 1'b1, {3'b111, 3'b110, 3'b101, 3'b100}, 0, lat);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        start     = 1'b0;
        ovr       = 1'b0;
        mult_bus  = '0;
        mcand_bus = '0;
        out_hi    = '0;
        for (int i = 0; i < 4; i++) ovr_dg[i] = 3'b000;
        test_reset();
        test_basic();
        test_negative();
        test_zero_skip();
        test_reset_mid_run();
        test_start_behaviour();
        test_back_to_back();
        test_all_codes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
